cvxif_offload_master: RTL

//  Core-side CVXIF master. Feeds the custom-3 coprocessor (complex add/conjugate) one instruction at a time.

---
 rtl/cvxif_pkg.sv | 38 +++
 rtl/cvxif_offload_master_if.sv | 39 +++
 rtl/cvxif_regfile.sv | 42 ++++
 rtl/cvxif_offload_master.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/cvxif_pkg.sv
// Shared types and constants for the core-side CVXIF offload master and its
// custom-3 complex-arithmetic coprocessor.
package cvxif_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_REGS,
        S_WAIT_RES,
        S_DONE
    } master_state_t;

    localparam logic [6:0] OPC_CUSTOM3 = 7'b1111011;
    localparam logic [2:0] F3_CADD     = 3'b000;
    localparam logic [2:0] F3_CCONJ    = 3'b001;

    localparam int unsigned RS1_LSB = 15;
    localparam int unsigned RS2_LSB = 20;
    localparam int unsigned RD_LSB  = 7;
    localparam int unsigned REG_W   = 5;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ILLEGAL = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    function automatic logic [4:0] rs1_of(input logic [31:0] ins);
        return ins[RS1_LSB +: REG_W];
    endfunction

    function automatic logic [4:0] rs2_of(input logic [31:0] ins);
        return ins[RS2_LSB +: REG_W];
    endfunction

    function automatic logic [4:0] rd_of(input logic [31:0] ins);
        return ins[RD_LSB +: REG_W];
    endfunction

endpackage

// File: rtl/cvxif_offload_master_if.sv
// Coprocessor-facing CVXIF bundle: issue, register and result handshakes.
interface cvxif_offload_master_if;

    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_req_instr;
    logic        issue_resp_accept;
    logic        issue_resp_writeback;
    logic [1:0]  issue_resp_register_read;

    logic        register_valid;
    logic        register_ready;
    logic [31:0] register_rs0;
    logic [31:0] register_rs1;
    logic [1:0]  register_rs_valid;

    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_data;

    modport master (
        output issue_valid, issue_req_instr,
        input  issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read,
        output register_valid, register_rs0, register_rs1, register_rs_valid,
        input  register_ready,
        input  result_valid, result_data,
        output result_ready
    );

    modport slave (
        input  issue_valid, issue_req_instr,
        output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read,
        input  register_valid, register_rs0, register_rs1, register_rs_valid,
        output register_ready,
        output result_valid, result_data,
        input  result_ready
    );

endinterface

// File: rtl/cvxif_regfile.sv
// 32x32 register file: x0 hardwired to zero, host and result write ports
// (result wins on an address clash), three asynchronous read ports.
module cvxif_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic        host_we,
    input  logic [4:0]  host_waddr,
    input  logic [31:0] host_wdata,
    input  logic        res_we,
    input  logic [4:0]  res_waddr,
    input  logic [31:0] res_wdata,
    input  logic [4:0]  raddr0,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2
);

    logic [31:0] rf [32];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < 32; i++) begin
                if (res_we && res_waddr == 5'(i)) begin
                    rf[i] <= res_wdata;
                end else if (host_we && host_waddr == 5'(i)) begin
                    rf[i] <= host_wdata;
                end
            end
        end
    end

    assign rdata0 = rf[raddr0];
    assign rdata1 = rf[raddr1];
    assign rdata2 = rf[raddr2];

endmodule

// File: rtl/cvxif_offload_master.sv
// Core-side CVXIF master: issues one instruction at a time to the custom-3
// coprocessor, supplies operands, writes back the result and reports completion.
module cvxif_offload_master
    import cvxif_pkg::*;
#(
    parameter int unsigned RESULT_TIMEOUT = 256,
    parameter bit          REG_READY_EN   = 1'b0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [31:0]            instr,
    input  logic                   host_we,
    input  logic [4:0]             host_waddr,
    input  logic [31:0]            host_wdata,
    input  logic [4:0]             host_raddr,
    output logic [31:0]            host_rdata,
    cvxif_offload_master_if.master cx,
    output logic                   done_valid,
    output logic [1:0]             done_status,
    output logic [4:0]             done_rd
);

    localparam logic [8:0] TMO_LAST = 9'(RESULT_TIMEOUT - 1);

    master_state_t state;
    logic [31:0]   instr_q;
    logic          wb_q;
    logic [8:0]    tmo_cnt;
    logic          res_we;

    // Result write is only honoured while the master is waiting for it.
    assign res_we             = (state == S_WAIT_RES) && cx.result_valid;
    assign cx.issue_req_instr = instr_q;

    cvxif_regfile u_regfile (
        .clk        (clk),
        .rst        (rst),
        .host_we    (host_we),
        .host_waddr (host_waddr),
        .host_wdata (host_wdata),
        .res_we     (res_we),
        .res_waddr  (rd_of(instr_q)),
        .res_wdata  (cx.result_data),
        .raddr0     (rs1_of(instr_q)),
        .raddr1     (rs2_of(instr_q)),
        .raddr2     (host_raddr),
        .rdata0     (cx.register_rs0),
        .rdata1     (cx.register_rs1),
        .rdata2     (host_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                <= S_IDLE;
            instr_q              <= '0;
            wb_q                 <= 1'b0;
            tmo_cnt              <= '0;
            instr_ready          <= 1'b1;
            cx.issue_valid       <= 1'b0;
            cx.register_valid    <= 1'b0;
            cx.register_rs_valid <= '0;
            cx.result_ready      <= 1'b0;
            done_valid           <= 1'b0;
            done_status          <= ST_OK;
            done_rd              <= '0;
        end else begin
            done_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q        <= instr;
                        instr_ready    <= 1'b0;
                        cx.issue_valid <= 1'b1;
                        state          <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cx.issue_ready) begin
                        cx.issue_valid <= 1'b0;
                        if (cx.issue_resp_accept) begin
                            wb_q                 <= cx.issue_resp_writeback;
                            cx.register_rs_valid <= cx.issue_resp_register_read;
                            cx.register_valid    <= 1'b1;
                            state                <= S_REGS;
                        end else begin
                            done_valid  <= 1'b1;
                            done_status <= ST_ILLEGAL;
                            done_rd     <= rd_of(instr_q);
                            state       <= S_DONE;
                        end
                    end
                end
                S_REGS: begin
                    if (!REG_READY_EN || cx.register_ready) begin
                        cx.register_valid <= 1'b0;
                        if (wb_q) begin
                            cx.result_ready <= 1'b1;
                            state           <= S_WAIT_RES;
                        end else begin
                            done_valid  <= 1'b1;
                            done_status <= ST_OK;
                            done_rd     <= rd_of(instr_q);
                            state       <= S_DONE;
                        end
                    end
                end
                S_WAIT_RES: begin
                    // A result arriving on the last allowed cycle still counts as success.
                    if (cx.result_valid) begin
                        cx.result_ready <= 1'b0;
                        tmo_cnt         <= '0;
                        done_valid      <= 1'b1;
                        done_status     <= ST_OK;
                        done_rd         <= rd_of(instr_q);
                        state           <= S_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        cx.result_ready <= 1'b0;
                        tmo_cnt         <= '0;
                        done_valid      <= 1'b1;
                        done_status     <= ST_TIMEOUT;
                        done_rd         <= rd_of(instr_q);
                        state           <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 9'd1;
                    end
                end
                S_DONE: begin
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
